// File: rtl/af_stage_pkg.sv
// Shared definitions for the activation-function stage.
// Holds the word-format defaults, enable/disable constants, the activation
// select encodings and the stage FSM state encodings.
// Optional feature macro: AF_LEAKY_EN (leaky ReLU on act_sel = 2).
package af_stage_pkg;

    localparam int unsigned AF_DW   = 16;
    localparam int unsigned AF_FRAC = 8;

    localparam bit ENABLE  = 1'b1;
    localparam bit DISABLE = 1'b0;

`ifdef AF_LEAKY_EN
    localparam bit AF_LEAKY_BUILT = ENABLE;
`else
    localparam bit AF_LEAKY_BUILT = DISABLE;
`endif

    // Activation select as presented on act_sel
    typedef enum logic [1:0] {
        ACT_ID    = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_HSIG  = 2'd3
    } act_sel_e;

    // Stage sequencing
    typedef enum logic [1:0] {
        AF_IDLE = 2'd0,
        AF_ADD  = 2'd1,
        AF_ACT  = 2'd2,
        AF_HOLD = 2'd3
    } af_state_e;

endpackage

// File: rtl/af_func.sv
// Combinational activation function on a saturated signed fixed-point word.
// Ports:
//   x       in  DW  saturated signed input, Q(DW-FRAC).FRAC
//   act_sel in  2   activation select (act_sel_e)
//   y_c     out DW  activation result (combinational)
// Optional feature macro: AF_LEAKY_EN. When undefined, no shifter for the
// leaky slope is built and ACT_LEAKY behaves as ReLU.
module af_func
    import af_stage_pkg::*;
#(
    parameter int unsigned DW   = AF_DW,
    parameter int unsigned FRAC = AF_FRAC
) (
    input  logic [DW-1:0] x,
    input  act_sel_e      act_sel,
    output logic [DW-1:0] y_c
);

    // Hard sigmoid constants: offset 0.5 and ceiling 1.0, one guard bit wide
    localparam logic signed [DW:0] HSIG_OFS = $signed((DW+1)'(1) << (FRAC-1));
    localparam logic signed [DW:0] HSIG_ONE = $signed((DW+1)'(1) << FRAC);

    logic signed [DW:0] x_ext;
    logic signed [DW:0] hsig_raw;

    // Hard sigmoid computed one bit wider so the offset can never wrap
    always_comb begin
        x_ext    = $signed({x[DW-1], x});
        hsig_raw = (x_ext >>> 2) + HSIG_OFS;
    end

    // Activation select
    always_comb begin
        y_c = x;
        case (act_sel)
            ACT_ID: begin
                y_c = x;
            end
`ifdef AF_LEAKY_EN
            ACT_RELU: begin
                y_c = x[DW-1] ? '0 : x;
            end
            ACT_LEAKY: begin
                y_c = x[DW-1] ? DW'($signed(x) >>> 3) : x;
            end
`else
            ACT_RELU, ACT_LEAKY: begin
                y_c = x[DW-1] ? '0 : x;
            end
`endif
            ACT_HSIG: begin
                if (hsig_raw[DW]) begin
                    y_c = '0;
                end else if (hsig_raw > HSIG_ONE) begin
                    y_c = HSIG_ONE[DW-1:0];
                end else begin
                    y_c = hsig_raw[DW-1:0];
                end
            end
            default: begin
                y_c = x;
            end
        endcase
    end

endmodule

// File: rtl/af_stage.sv
// Activation-function stage: captures the final accumulator sum of a neuron,
// adds the bias with saturation, applies the selected activation and holds
// the result on a valid/ack handshake. One pending slot absorbs a final sum
// arriving while a result is in flight, so the accumulator never stalls.
// Ports:
//   clk      in  1   clock
//   reset    in  1   asynchronous active-high reset
//   ac_out   in  DW  accumulator value (signed)
//   ac_rdy   in  1   accumulator value valid
//   off      in  1   with ac_rdy: ac_out is the final sum
//   bias     in  DW  signed bias, sampled with the final sum
//   act_sel  in  2   activation select, sampled with the final sum
//   af_out   out DW  activation result (signed)
//   af_vld   out 1   af_out valid, held until af_ack
//   af_ack   in  1   consumer accepts af_out
//   busy     out 1   FSM not idle or pending slot full
//   ovf      out 1   sticky: a final sum was dropped
// Optional feature macro: AF_LEAKY_EN (passed through to af_func).
module af_stage
    import af_stage_pkg::*;
#(
    parameter int unsigned DW   = AF_DW,
    parameter int unsigned FRAC = AF_FRAC
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] ac_out,
    input  logic          ac_rdy,
    input  logic          off,
    input  logic [DW-1:0] bias,
    input  logic [1:0]    act_sel,
    output logic [DW-1:0] af_out,
    output logic          af_vld,
    input  logic          af_ack,
    output logic          busy,
    output logic          ovf
);

    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    af_state_e     state_q,     state_d;
    logic [DW-1:0] wrk_acc_q,   wrk_acc_d;
    logic [DW-1:0] wrk_bias_q,  wrk_bias_d;
    act_sel_e      wrk_sel_q,   wrk_sel_d;
    logic [DW-1:0] wrk_sum_q,   wrk_sum_d;
    logic          pend_vld_q,  pend_vld_d;
    logic [DW-1:0] pend_acc_q,  pend_acc_d;
    logic [DW-1:0] pend_bias_q, pend_bias_d;
    act_sel_e      pend_sel_q,  pend_sel_d;
    logic [DW-1:0] af_out_d;
    logic          af_vld_d;
    logic          busy_d;
    logic          ovf_d;

    logic          arrival_c;
    logic          drain_c;
    logic          load_in_c;
    logic [DW:0]   sum_wide_c;
    logic [DW-1:0] sum_sat_c;
    logic [DW-1:0] act_y_c;

    assign arrival_c = ac_rdy & off;

    // Bias add one bit wide, then clamp to the signed DW range
    always_comb begin
        sum_wide_c = {wrk_acc_q[DW-1], wrk_acc_q} + {wrk_bias_q[DW-1], wrk_bias_q};
        sum_sat_c  = sum_wide_c[DW-1:0];
        if (sum_wide_c[DW] != sum_wide_c[DW-1]) begin
            sum_sat_c = sum_wide_c[DW] ? SAT_MIN : SAT_MAX;
        end
    end

    af_func #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_af_func (
        .x       (wrk_sum_q),
        .act_sel (wrk_sel_q),
        .y_c     (act_y_c)
    );

    // Next-state, working/pending registers and outputs
    always_comb begin
        state_d     = state_q;
        wrk_acc_d   = wrk_acc_q;
        wrk_bias_d  = wrk_bias_q;
        wrk_sel_d   = wrk_sel_q;
        wrk_sum_d   = wrk_sum_q;
        pend_vld_d  = pend_vld_q;
        pend_acc_d  = pend_acc_q;
        pend_bias_d = pend_bias_q;
        pend_sel_d  = pend_sel_q;
        af_out_d    = af_out;
        af_vld_d    = af_vld;
        ovf_d       = ovf;
        drain_c     = 1'b0;
        load_in_c   = 1'b0;

        case (state_q)
            AF_IDLE: begin
                // A pending entry left behind by a HOLD exit takes priority
                if (pend_vld_q) begin
                    drain_c = 1'b1;
                    state_d = AF_ADD;
                end else if (arrival_c) begin
                    load_in_c = 1'b1;
                    state_d   = AF_ADD;
                end
            end
            AF_ADD: begin
                wrk_sum_d = sum_sat_c;
                state_d   = AF_ACT;
            end
            AF_ACT: begin
                af_out_d = act_y_c;
                af_vld_d = 1'b1;
                state_d  = AF_HOLD;
            end
            AF_HOLD: begin
                if (af_ack) begin
                    af_vld_d = 1'b0;
                    if (pend_vld_q) begin
                        drain_c = 1'b1;
                        state_d = AF_ADD;
                    end else begin
                        state_d = AF_IDLE;
                    end
                end
            end
            default: begin
                state_d = AF_IDLE;
            end
        endcase

        if (load_in_c) begin
            wrk_acc_d  = ac_out;
            wrk_bias_d = bias;
            wrk_sel_d  = act_sel_e'(act_sel);
        end

        // Draining frees the slot, so a same-cycle arrival refills it
        if (drain_c) begin
            wrk_acc_d  = pend_acc_q;
            wrk_bias_d = pend_bias_q;
            wrk_sel_d  = pend_sel_q;
            pend_vld_d = 1'b0;
        end

        if (arrival_c && !load_in_c) begin
            if (!pend_vld_q || drain_c) begin
                pend_vld_d  = 1'b1;
                pend_acc_d  = ac_out;
                pend_bias_d = bias;
                pend_sel_d  = act_sel_e'(act_sel);
            end else begin
                ovf_d = 1'b1;
            end
        end

        busy_d = (state_d != AF_IDLE) || pend_vld_d;
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= AF_IDLE;
            wrk_acc_q   <= '0;
            wrk_bias_q  <= '0;
            wrk_sel_q   <= ACT_ID;
            wrk_sum_q   <= '0;
            pend_vld_q  <= 1'b0;
            pend_acc_q  <= '0;
            pend_bias_q <= '0;
            pend_sel_q  <= ACT_ID;
            af_out      <= '0;
            af_vld      <= 1'b0;
            busy        <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrk_acc_q   <= wrk_acc_d;
            wrk_bias_q  <= wrk_bias_d;
            wrk_sel_q   <= wrk_sel_d;
            wrk_sum_q   <= wrk_sum_d;
            pend_vld_q  <= pend_vld_d;
            pend_acc_q  <= pend_acc_d;
            pend_bias_q <= pend_bias_d;
            pend_sel_q  <= pend_sel_d;
            af_out      <= af_out_d;
            af_vld      <= af_vld_d;
            busy        <= busy_d;
            ovf         <= ovf_d;
        end
    end

endmodule

// File: tb/tb_af_stage.sv
// Directed self-checking bench for af_stage (DW=16, FRAC=8).
module tb_af_stage;

    logic        clk;
    logic        reset;
    logic [15:0] ac_out;
    logic        ac_rdy;
    logic        off;
    logic [15:0] bias;
    logic [1:0]  act_sel;
    logic [15:0] af_out;
    logic        af_vld;
    logic        af_ack;
    logic        busy;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    af_stage #(
        .DW   (16),
        .FRAC (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ac_out  (ac_out),
        .ac_rdy  (ac_rdy),
        .off     (off),
        .bias    (bias),
        .act_sel (act_sel),
        .af_out  (af_out),
        .af_vld  (af_vld),
        .af_ack  (af_ack),
        .busy    (busy),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one final sum for a single cycle
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s);
        ac_out  = a;
        bias    = b;
        act_sel = s;
        ac_rdy  = 1'b1;
        off     = 1'b1;
        step();
        ac_rdy  = 1'b0;
        off     = 1'b0;
    endtask

    // Single result with af_ack high: checks exact N+3 latency and the pulse
    task automatic one(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s,
                       input logic [15:0] e, input string tag);
        send(a, b, s);
        chk({tag, "_busy_add"}, 32'(busy), 32'd1);
        chk({tag, "_vld_n1"}, 32'(af_vld), 32'd0);
        step();
        chk({tag, "_vld_n2"}, 32'(af_vld), 32'd0);
        step();
        chk({tag, "_vld_n3"}, 32'(af_vld), 32'd1);
        chk({tag, "_out"}, 32'(af_out), 32'(e));
        step();
        chk({tag, "_vld_n4"}, 32'(af_vld), 32'd0);
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        ac_out  = '0;
        ac_rdy  = 1'b0;
        off     = 1'b0;
        bias    = '0;
        act_sel = 2'd0;
        af_ack  = 1'b1;
        step();
        chk("rst_out", 32'(af_out), 32'd0);
        chk("rst_vld", 32'(af_vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b0;
        step();

        // ReLU: 3.0 - 2.0 = 1.0; -4.0 - 2.0 clamps to 0
        one(16'h0300, 16'hFE00, 2'd1, 16'h0100, "relu_pos");
        one(16'hFC00, 16'hFE00, 2'd1, 16'h0000, "relu_neg");

        // Saturation on the bias add
        one(16'h7F00, 16'h0200, 2'd0, 16'h7FFF, "sat_pos");
        one(16'h8100, 16'hFE00, 2'd0, 16'h8000, "sat_neg");

        // Hard sigmoid
        one(16'h0000, 16'h0000, 2'd3, 16'h0080, "hsig_zero");
        one(16'h0400, 16'h0000, 2'd3, 16'h0100, "hsig_top");
        one(16'hFC00, 16'h0000, 2'd3, 16'h0000, "hsig_bot");
        one(16'h0100, 16'h0000, 2'd3, 16'h00C0, "hsig_mid");

        // Leaky select: -8.0 -> -1.0 with the feature, ReLU otherwise
`ifdef AF_LEAKY_EN
        one(16'hF800, 16'h0000, 2'd2, 16'hFF00, "leaky_neg");
`else
        one(16'hF800, 16'h0000, 2'd2, 16'h0000, "leaky_neg");
`endif
        one(16'h0280, 16'h0000, 2'd2, 16'h0280, "leaky_pos");

        // Filtering: ac_rdy without off, then off without ac_rdy
        ac_out = 16'h1234;
        ac_rdy = 1'b1;
        off    = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("filt_rdy_vld", 32'(af_vld), 32'd0);
        chk("filt_rdy_busy", 32'(busy), 32'd0);
        ac_rdy = 1'b0;
        off    = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("filt_off_vld", 32'(af_vld), 32'd0);
        chk("filt_off_busy", 32'(busy), 32'd0);
        off = 1'b0;

        // Backpressure: A held, B pending, C dropped
        af_ack = 1'b0;
        send(16'h0100, 16'h0000, 2'd0);
        step();
        step();
        chk("bp_a_vld", 32'(af_vld), 32'd1);
        chk("bp_a_out", 32'(af_out), 32'h0100);
        step();
        send(16'h0200, 16'h0000, 2'd0);
        chk("bp_b_ovf", 32'(ovf), 32'd0);
        chk("bp_b_busy", 32'(busy), 32'd1);
        chk("bp_b_hold", 32'(af_out), 32'h0100);
        step();
        step();
        step();
        send(16'h0300, 16'h0000, 2'd0);
        chk("bp_c_ovf", 32'(ovf), 32'd1);
        chk("bp_c_vld", 32'(af_vld), 32'd1);
        chk("bp_c_hold", 32'(af_out), 32'h0100);
        af_ack = 1'b1;
        step();
        chk("bp_ack_vld", 32'(af_vld), 32'd0);
        step();
        step();
        chk("bp_b_vld", 32'(af_vld), 32'd1);
        chk("bp_b_out", 32'(af_out), 32'h0200);
        step();
        chk("bp_end_vld", 32'(af_vld), 32'd0);
        chk("bp_end_busy", 32'(busy), 32'd0);
        chk("bp_end_ovf", 32'(ovf), 32'd1);
        for (int i = 0; i < 4; i++) step();
        chk("bp_c_gone", 32'(af_vld), 32'd0);

        // Reset during ADD clears everything at once
        send(16'h0500, 16'h0000, 2'd0);
        chk("radd_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("radd_out", 32'(af_out), 32'd0);
        chk("radd_vld", 32'(af_vld), 32'd0);
        chk("radd_busy0", 32'(busy), 32'd0);
        chk("radd_ovf", 32'(ovf), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("radd_idle_vld", 32'(af_vld), 32'd0);
        chk("radd_idle_busy", 32'(busy), 32'd0);
        one(16'h0600, 16'h0000, 2'd0, 16'h0600, "post_rst");

        // Drain and arrival in the same cycle: P2 then D, no overflow
        af_ack = 1'b0;
        send(16'h0100, 16'h0000, 2'd1);
        step();
        step();
        chk("dr_p1_vld", 32'(af_vld), 32'd1);
        chk("dr_p1_out", 32'(af_out), 32'h0100);
        send(16'h0200, 16'h0000, 2'd0);
        chk("dr_p2_busy", 32'(busy), 32'd1);
        ac_out  = 16'h0300;
        bias    = 16'h0000;
        act_sel = 2'd0;
        ac_rdy  = 1'b1;
        off     = 1'b1;
        af_ack  = 1'b1;
        step();
        ac_rdy = 1'b0;
        off    = 1'b0;
        chk("dr_ovf", 32'(ovf), 32'd0);
        chk("dr_vld0", 32'(af_vld), 32'd0);
        chk("dr_busy", 32'(busy), 32'd1);
        step();
        step();
        chk("dr_p2_vld", 32'(af_vld), 32'd1);
        chk("dr_p2_out", 32'(af_out), 32'h0200);
        step();
        chk("dr_gap_vld", 32'(af_vld), 32'd0);
        step();
        step();
        chk("dr_d_vld", 32'(af_vld), 32'd1);
        chk("dr_d_out", 32'(af_out), 32'h0300);
        step();
        chk("dr_end_vld", 32'(af_vld), 32'd0);
        chk("dr_end_busy", 32'(busy), 32'd0);
        chk("dr_end_ovf", 32'(ovf), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
